// File: rtl/debounce_scheduler_pkg.sv
// Shared types and constants for the debounce scheduler.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int N_BTN_MIN        = 1;
  localparam int N_BTN_MAX        = 16;
  localparam int TICK_DIV_MIN     = 2;
  localparam int STABLE_TICKS_MIN = 2;
  localparam int STABLE_TICKS_MAX = 15;

  // Smallest r with 2**r >= v.
  function automatic int ceillog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int n_btn, input int tick_div, input int stable);
    return (n_btn >= N_BTN_MIN) && (n_btn <= N_BTN_MAX) &&
           (tick_div >= TICK_DIV_MIN) &&
           (stable >= STABLE_TICKS_MIN) && (stable <= STABLE_TICKS_MAX);
  endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Button-side bus: raw inputs and run control in, clean levels/pulses out.
interface debounce_scheduler_if #(
  parameter int N_BTN = 4
);
  logic             enable;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             tick;

  modport master (output enable, btn_in,
                  input  btn_level, btn_press, btn_release, tick);
  modport slave  (input  enable, btn_in,
                  output btn_level, btn_press, btn_release, tick);
endinterface

// File: rtl/debounce_scheduler_tick_gen.sv
// Shared sample-tick generator: one registered pulse every TICK_DIV enabled cycles.
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic enable,
  output logic tick
);
  localparam int             CW   = ceillog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Wrap the divider at TICK_DIV-1 and flag the wrap; freeze when disabled.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel button debouncer sharing one sample tick across all channels.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 5000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_a_p,
  debounce_scheduler_if.slave  bus
);
  localparam int            SW     = ceillog2(STABLE_TICKS + 1);
  localparam logic [SW-1:0] STABLE = SW'(STABLE_TICKS);

  if (!params_ok(N_BTN, TICK_DIV, STABLE_TICKS)) begin : g_param_err
    $error("debounce_scheduler: parameter out of range");
  end

  logic             tick;
  logic             act;
  logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  wire  [N_BTN-1:0] level_w, press_w, release_w;

  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_a_p (rst_a_p),
    .enable  (bus.enable),
    .tick    (tick)
  );

  // Channel FSMs evaluate only on an enabled tick.
  assign act = tick & bus.enable;

  // Two-stage synchronizer feed.
  always_comb begin
    sync1_d = bus.btn_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_state_e    state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          level_q, level_d, press_q, press_d, rel_q, rel_d;
    logic          s;

    assign s       = sync2_q[i];
    assign cnt_inc = cnt_q + SW'(1);

    // State, pend counter and registered outputs.
    always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Next state: a disagreeing sample restarts the pend count from scratch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (act) begin
        case (state_q)
          RELEASED:
            if (s) begin state_d = PRESS_PEND; cnt_d = SW'(1); end
          PRESS_PEND:
            if (!s)                    begin state_d = RELEASED; cnt_d = '0; end
            else if (cnt_inc == STABLE) begin state_d = PRESSED;  cnt_d = '0; end
            else                        cnt_d = cnt_inc;
          PRESSED:
            if (!s) begin state_d = RELEASE_PEND; cnt_d = SW'(1); end
          RELEASE_PEND:
            if (s)                     begin state_d = PRESSED;  cnt_d = '0; end
            else if (cnt_inc == STABLE) begin state_d = RELEASED; cnt_d = '0; end
            else                        cnt_d = cnt_inc;
          default: begin state_d = RELEASED; cnt_d = '0; end
        endcase
      end
    end

    // Outputs: level follows confirmed transitions, pulses last one cycle.
    always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (act) begin
        if (state_q == PRESS_PEND && s && cnt_inc == STABLE) begin
          level_d = 1'b1;
          press_d = 1'b1;
        end
        if (state_q == RELEASE_PEND && !s && cnt_inc == STABLE) begin
          level_d = 1'b0;
          rel_d   = 1'b1;
        end
      end
    end

    assign level_w[i]   = level_q;
    assign press_w[i]   = press_q;
    assign release_w[i] = rel_q;
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.tick        = tick;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios plus random traffic against a run-length model.
module tb_debounce_scheduler;
  localparam int NB = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debounce_scheduler_if #(.N_BTN(NB)) bus ();

  debounce_scheduler #(.N_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk     (clk),
    .rst_a_p (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: s is btn_in two clocks old; tick follows the count of enabled cycles;
  // each channel counts consecutive samples that disagree with its level.
  logic [NB-1:0] m_h1, m_h2, m_level, m_press, m_rel;
  logic          m_tick;
  int            m_en_cycles, m_run[NB], ecount;

  // Observation trackers.
  int first_tick, first_press0, press_cnt[NB], rel_cnt[NB], saw_p1100, saw_r1100;

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    m_tick = 1'b0; m_en_cycles = 0; ecount = 0;
    for (int c = 0; c < NB; c++) m_run[c] = 0;
  endtask

  task automatic model_edge();
    logic          act;
    logic [NB-1:0] s;
    act = m_tick && bus.enable;
    s   = m_h2;
    m_press = '0;
    m_rel   = '0;
    if (act)
      for (int c = 0; c < NB; c++) begin
        if (s[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == ST) begin
            m_level[c] = s[c];
            if (s[c]) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
            m_run[c] = 0;
          end
        end else m_run[c] = 0;
      end
    m_tick = bus.enable && ((m_en_cycles % TD) == TD - 1);
    if (bus.enable) m_en_cycles++;
    m_h2 = m_h1;
    m_h1 = bus.btn_in;
    ecount++;
  endtask

  task automatic pin(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Single compare process: update model on each edge, check DUT shortly after.
  initial forever begin
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    tests++;
    if (bus.tick !== m_tick || bus.btn_level !== m_level ||
        bus.btn_press !== m_press || bus.btn_release !== m_rel) begin
      fails++;
      $display("FAIL outputs @edge%0d: tick/level/press/rel got %b/%b/%b/%b expected %b/%b/%b/%b",
               ecount, bus.tick, bus.btn_level, bus.btn_press, bus.btn_release,
               m_tick, m_level, m_press, m_rel);
    end
    if (bus.tick === 1'b1 && first_tick < 0) first_tick = ecount;
    if (bus.btn_press[0] === 1'b1 && first_press0 < 0) first_press0 = ecount;
    for (int c = 0; c < NB; c++) begin
      if (bus.btn_press[c] === 1'b1) press_cnt[c]++;
      if (bus.btn_release[c] === 1'b1) rel_cnt[c]++;
    end
    if (bus.btn_press[3:2] === 2'b11) saw_p1100++;
    if (bus.btn_release[3:2] === 2'b11) saw_r1100++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    first_tick = -1;
    first_press0 = -1;
    rst = 1'b0;
  endtask

  initial begin
    int p0, r0, p1, bound;
    bus.enable = 1'b1;
    bus.btn_in = '0;
    first_tick = -1;
    first_press0 = -1;
    saw_p1100 = 0;
    saw_r1100 = 0;
    for (int c = 0; c < NB; c++) begin press_cnt[c] = 0; rel_cnt[c] = 0; end
    cycles(3);
    rst = 1'b0;

    // Idle: first tick four clocks after release, no pulses.
    cycles(100);
    pin("first_tick_edge", first_tick, 4);
    pin("idle_presses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Channel 0 held from reset release: press one clock after the third tick.
    bus.btn_in = 4'b0001;
    do_reset();
    cycles(30);
    pin("press0_edge", first_press0, 13);
    pin("level_after_press0", int'(bus.btn_level), 1);
    pin("others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Channel 1 bounce: 2 high samples, 1 low, 3 high -> one press.
    p1 = press_cnt[1];
    bus.btn_in[1] = 1'b1; cycles(2 * TD);
    bus.btn_in[1] = 1'b0; cycles(1 * TD);
    pin("bounce_no_early_press", press_cnt[1] - p1, 0);
    bus.btn_in[1] = 1'b1; cycles(3 * TD + 8);
    pin("bounce_one_press", press_cnt[1] - p1, 1);
    bus.btn_in[1] = 1'b0; cycles(5 * TD);

    // Channels 2 and 3 together.
    bus.btn_in[3:2] = 2'b11; cycles(5 * TD);
    bus.btn_in[3:2] = 2'b00; cycles(5 * TD);
    pin("joint_press_1100", saw_p1100, 1);
    pin("joint_release_1100", saw_r1100, 1);

    // Reset while channel 0 is two samples into a press.
    bus.btn_in = '0; cycles(6 * TD);
    bus.btn_in[0] = 1'b1;
    p0 = press_cnt[0];
    bound = 0;
    while (m_run[0] != 2 && bound < 60) begin @(negedge clk); bound++; end
    pin("pend_reached", int'(m_run[0] == 2), 1);
    do_reset();
    cycles(30);
    pin("pend_reset_fresh_press_edge", first_press0, 13);
    pin("pend_reset_single_press", press_cnt[0] - p0, 1);

    // Frozen while disabled; resumes afterwards.
    p0 = press_cnt[0];
    r0 = rel_cnt[0];
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 0) bus.btn_in[0] = ~bus.btn_in[0];
      @(negedge clk);
    end
    pin("frozen_level", int'(bus.btn_level), 1);
    pin("frozen_pulses", (press_cnt[0] - p0) + (rel_cnt[0] - r0), 0);
    bus.btn_in[0] = 1'b0;
    bus.enable = 1'b1;
    cycles(5 * TD);
    pin("resume_release", rel_cnt[0] - r0, 1);

    // Random traffic with occasional freeze and reset.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 9) == 0) bus.btn_in[c] = ~bus.btn_in[c];
      if ($urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    cycles(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_BTN raw, asynchronous push-button inputs using one shared sample-tick generator instead of one counter per button.
- Every sample tick, each channel's synchronized level is evaluated by a per-channel FSM.
- Outputs are a clean level plus single-cycle press and release pulses.
- Sits between board pins and the user logic: counters, mode selects, etc.

Parameters:
- N_BTN, 4, number of button channels (1..16).
- TICK_DIV, 5000, clk cycles per sample tick (>=2).
- STABLE_TICKS, 4, consecutive identical samples required to change state (2..15).

Ports:
- clk  in  1  system clock.
- rst_a_p  in  1  asynchronous reset, active-high.
- enable  in  1  1 = run; 0 = freeze tick counter and all channel FSMs.
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  out  N_BTN  debounced level per channel.
- btn_press  out  N_BTN  1-cycle pulse on debounced 0->1.
- btn_release  out  N_BTN  1-cycle pulse on debounced 1->0.
- tick  out  1  shared sample tick, 1 cycle wide, exported for debug.

Behaviour:
- Reset (rst_a_p=1, async): all outputs 0, synchronizers 0, tick counter 0, every FSM in RELEASED, stable counters 0. Reset mid-operation aborts any pending state with no pulse emitted.
- Synchronizer: 2-FF per channel. The sampled value s[i] is btn_in delayed 2 clk.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is registered, high for exactly the cycle after the counter reaches TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset release with enable=1.
  - enable=0: counter holds its value, tick=0.
- Channel FSM (per channel, acts only in cycles with tick=1 and enable=1; state, counters and btn_level otherwise hold):
  - RELEASED: s=1 -> PRESS_PEND, cnt=1. s=0 -> stay.
  - PRESS_PEND:
    - s=1 and cnt+1==STABLE_TICKS -> PRESSED, cnt=0, btn_level<=1, btn_press pulse.
    - s=1 otherwise -> cnt+1.
    - s=0 -> RELEASED, cnt=0, no pulse.
  - PRESSED: s=0 -> RELEASE_PEND, cnt=1. s=1 -> stay.
  - RELEASE_PEND:
    - s=0 and cnt+1==STABLE_TICKS -> RELEASED, cnt=0, btn_level<=0, btn_release pulse.
    - s=0 otherwise -> cnt+1.
    - s=1 -> PRESSED, cnt=0, no pulse.
- Latency: btn_level and the pulse are registered and appear 1 clk after the tick carrying the STABLE_TICKS-th consecutive agreeing sample. Pulses are exactly 1 clk wide.
- Simultaneous events: channels are independent. Any subset may pulse in the same cycle, with no priority or serialization.
- Bounce rejection: a differing sample resets the pend counter. A glitch shorter than STABLE_TICKS consecutive ticks never changes btn_level.
- Width rules:
  - Tick counter width ceillog2(TICK_DIV).
  - Stable counter width ceillog2(STABLE_TICKS+1).
  - No overflow is possible because the counters saturate by state exit.
- Illegal FSM encodings recover to RELEASED on the next tick.

Decomposition:
- Package debounce_pkg holds:
  - the 2-bit state encodings RELEASED=0, PRESS_PEND=1, PRESSED=2, RELEASE_PEND=3;
  - the ceillog2 constant function;
  - parameter range-check constants.
- Sub-module debounce_tick_gen (params TICK_DIV; ports clk, rst_a_p, enable, tick) is instantiated once.
- Channel FSMs are a generate loop inside debounce_scheduler.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, N_BTN=4 unless noted):
- Reset release with btn_in=0000 -> all outputs 0; tick every 4 clk, first at clk 4; no pulses over 100 clk.
- btn_in[0]=1 held -> btn_level[0]=1 and btn_press[0]=1 (1 clk), 1 clk after the 3rd tick sampling s[0]=1. Other channels stay 0.
- btn_in[1] high for 2 ticks, low 1 tick, high 3 ticks -> exactly one btn_press[1], occurring after the final 3rd consecutive high tick.
- Channels 2,3 pressed in the same cycle, then released together -> btn_press=1100 in one cycle, later btn_release=1100 in one cycle.
- Reset asserted while channel 0 is in PRESS_PEND (cnt=2) -> no pulse; after release, 3 fresh high ticks are required.
- enable=0 for 20 clk with btn_in[0] toggling -> tick=0, no pulses, btn_level unchanged; debouncing resumes from the frozen state when enable=1.
